vend_payout_ctrl: RTL and testbench
===================================

VEND_PAYOUT_CTRL -- requirements
Module: vend_payout_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, which is the max cycles to wait for any acknowledge (1..65535).
REQ-002 SHALL have parameter PULSE_W, default 2, which is the coin_pulse high width in cycles (1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req, input, 1 bit: one-cycle request strobe from the vending FSM.
REQ-006 SHALL have port vend, input, 1 bit: sampled with req; 1 = dispense one product.
REQ-007 SHALL have port change, input, 2 bits: sampled with req; number of 5-unit coins to pay out (0..3).
REQ-008 SHALL have port motor_done, input, 1 bit: product motor acknowledge (level, from motor sensor).
REQ-009 SHALL have port coin_sense, input, 1 bit: hopper coin-exit sensor, one pulse per coin.
REQ-010 SHALL have port busy, output, 1 bit: high while a request is being serviced.
REQ-011 SHALL have port motor_on, output, 1 bit: product motor drive.
REQ-012 SHALL have port coin_pulse, output, 1 bit: hopper eject drive.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse at successful completion.
REQ-014 SHALL have port fault, output, 1 bit: sticky timeout fault.
REQ-015 SHALL have port coins_paid, output, 2 bits: coins confirmed by coin_sense for the current or last request.

Function
REQ-016 SHALL implement states IDLE, MOTOR, COIN_DRV, COIN_WAIT, DONE, FAULT; all outputs registered.
REQ-017 IDLE: on req=1, SHALL latch vend/change, clear coins_paid, assert busy next cycle; go MOTOR if vend=1, else COIN_DRV if change!=0, else DONE.
REQ-018 SHALL ignore req while busy=1 or in FAULT, with no queuing and no latch update.
REQ-019 MOTOR: motor_on=1 until motor_done=1 is sampled; then motor_on=0, go COIN_DRV if latched change!=0, else DONE.
REQ-020 COIN_DRV: coin_pulse=1 for exactly PULSE_W cycles, then go COIN_WAIT.
REQ-021 COIN_WAIT: on a coin_sense rising edge (edge-detected internally), SHALL increment coins_paid; go COIN_DRV if coins_paid+1 < latched change, else DONE.
REQ-022 DONE: done=1 for one cycle, busy=0 on the following cycle, return to IDLE; earliest new req accepted the cycle after DONE.
REQ-023 Latency: vend=0, change=0 request SHALL assert done 2 cycles after the req cycle.
REQ-024 Timeout counter SHALL reset on each entry to MOTOR or COIN_WAIT; reaching TIMEOUT cycles SHALL move to FAULT.
REQ-025 FAULT: fault=1, busy=1, motor_on=0, coin_pulse=0; held until rst; coins_paid frozen.
REQ-026 A coin_sense edge outside COIN_WAIT SHALL be ignored; coins_paid SHALL not exceed latched change.
REQ-027 A simultaneous ack and timeout in the same cycle SHALL be resolved as ack wins.

Reset
REQ-028 rst=1 SHALL immediately force IDLE with busy, motor_on, coin_pulse, done and fault =0 and coins_paid=00, including mid-operation.
REQ-029 After rst deasserts, the first req SHALL be accepted on the first rising edge.

Configuration
REQ-030 Macro PAYOUT_TIMEOUT_EN defined: SHALL compile in the timeout counter and FAULT state per REQ-024..027.
REQ-031 Macro PAYOUT_TIMEOUT_EN undefined: SHALL omit the counter and FAULT state, wait indefinitely for acks, and tie fault to 0.

Verification
REQ-032 Bench SHALL cover: req, vend=1, change=00, motor_done high 5 cycles later -> motor_on high 5 cycles, done pulse, coins_paid=0.
REQ-033 Bench SHALL cover: req, vend=1, change=10, PULSE_W=2 -> motor phase, then two 2-cycle coin_pulse bursts each answered by coin_sense, coins_paid=2, one done pulse.
REQ-034 Bench SHALL cover: req, vend=0, change=00 -> done 2 cycles after req, no motor or coin activity.
REQ-035 Bench SHALL cover: with PAYOUT_TIMEOUT_EN, TIMEOUT=20, change=01, no coin_sense -> fault=1 20 cycles after COIN_WAIT entry, busy stays 1, a later req is ignored.
REQ-036 Bench SHALL cover: rst asserted mid-COIN_WAIT -> all outputs 0 asynchronously, next req serviced normally.
REQ-037 Bench SHALL cover: req pulsed while busy plus spurious coin_sense in IDLE -> no effect on latched request or coins_paid.

Source files
------------

// File: rtl/vend_payout_ctrl.sv
// Vending payout controller: runs the product motor, then ejects change coins one at a time.
// Define PAYOUT_TIMEOUT_EN to add the acknowledge timeout and the sticky FAULT state.
module vend_payout_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned PULSE_W = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic       vend,
   input  logic [1:0] change,
   input  logic       motor_done,
   input  logic       coin_sense,
   output logic       busy,
   output logic       motor_on,
   output logic       coin_pulse,
   output logic       done,
   output logic       fault,
   output logic [1:0] coins_paid
);

   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("vend_payout_ctrl: TIMEOUT must be 1..65535");
   end
   if (PULSE_W < 1 || PULSE_W > 15) begin : g_bad_pulse_w
      $error("vend_payout_ctrl: PULSE_W must be 1..15");
   end

   localparam logic [3:0] PULSE_LAST = 4'(PULSE_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MOTOR,
      S_COIN_DRV,
      S_COIN_WAIT,
      S_DONE
`ifdef PAYOUT_TIMEOUT_EN
      , S_FAULT
`endif
   } state_t;

   state_t     r_state;
   logic       r_busy;
   logic       r_motor_on;
   logic       r_coin_pulse;
   logic       r_done;
   logic [1:0] r_coins;
   logic [1:0] r_change;
   logic [3:0] r_pcnt;
   logic       r_sense_d;

   logic       w_sense_rise;
   logic [1:0] w_coins_nxt;

`ifdef PAYOUT_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   logic [15:0] r_tmo;
   logic        r_fault;
   assign fault = r_fault;
`else
   assign fault = 1'b0;
`endif

   // Coins are only counted while waiting, so the edge register runs unconditionally.
   assign w_sense_rise = coin_sense & ~r_sense_d;
   assign w_coins_nxt  = r_coins + 2'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_busy       <= 1'b0;
         r_motor_on   <= 1'b0;
         r_coin_pulse <= 1'b0;
         r_done       <= 1'b0;
         r_coins      <= 2'd0;
         r_change     <= 2'd0;
         r_pcnt       <= 4'd0;
         r_sense_d    <= 1'b0;
`ifdef PAYOUT_TIMEOUT_EN
         r_tmo        <= 16'd0;
         r_fault      <= 1'b0;
`endif
      end else begin
         r_sense_d <= coin_sense;
         r_done    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // busy is still high in the cycle done pulses; that cycle drops it instead of accepting.
               if (r_busy) begin
                  r_busy <= 1'b0;
               end else if (req) begin
                  r_busy   <= 1'b1;
                  r_change <= change;
                  r_coins  <= 2'd0;
                  if (vend) begin
                     r_state    <= S_MOTOR;
                     r_motor_on <= 1'b1;
`ifdef PAYOUT_TIMEOUT_EN
                     r_tmo      <= 16'd0;
`endif
                  end else if (change != 2'd0) begin
                     r_state      <= S_COIN_DRV;
                     r_coin_pulse <= 1'b1;
                     r_pcnt       <= PULSE_LAST;
                  end else begin
                     r_state <= S_DONE;
                  end
               end
            end

            S_MOTOR: begin
               if (motor_done) begin
                  r_motor_on <= 1'b0;
                  if (r_change != 2'd0) begin
                     r_state      <= S_COIN_DRV;
                     r_coin_pulse <= 1'b1;
                     r_pcnt       <= PULSE_LAST;
                  end else begin
                     r_state <= S_DONE;
                  end
               end
`ifdef PAYOUT_TIMEOUT_EN
               else if (r_tmo == TMO_LAST) begin
                  r_state    <= S_FAULT;
                  r_motor_on <= 1'b0;
                  r_fault    <= 1'b1;
               end else begin
                  r_tmo <= r_tmo + 16'd1;
               end
`endif
            end

            S_COIN_DRV: begin
               if (r_pcnt == 4'd0) begin
                  r_state      <= S_COIN_WAIT;
                  r_coin_pulse <= 1'b0;
`ifdef PAYOUT_TIMEOUT_EN
                  r_tmo        <= 16'd0;
`endif
               end else begin
                  r_pcnt <= r_pcnt - 4'd1;
               end
            end

            S_COIN_WAIT: begin
               // An ack seen in the same cycle the timer expires still counts as success.
               if (w_sense_rise) begin
                  r_coins <= w_coins_nxt;
                  if (w_coins_nxt < r_change) begin
                     r_state      <= S_COIN_DRV;
                     r_coin_pulse <= 1'b1;
                     r_pcnt       <= PULSE_LAST;
                  end else begin
                     r_state <= S_DONE;
                  end
               end
`ifdef PAYOUT_TIMEOUT_EN
               else if (r_tmo == TMO_LAST) begin
                  r_state <= S_FAULT;
                  r_fault <= 1'b1;
               end else begin
                  r_tmo <= r_tmo + 16'd1;
               end
`endif
            end

            S_DONE: begin
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end

`ifdef PAYOUT_TIMEOUT_EN
            S_FAULT: begin
               r_busy       <= 1'b1;
               r_fault      <= 1'b1;
               r_motor_on   <= 1'b0;
               r_coin_pulse <= 1'b0;
            end
`endif

            default: begin
               r_state      <= S_IDLE;
               r_busy       <= 1'b0;
               r_motor_on   <= 1'b0;
               r_coin_pulse <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = r_busy;
   assign motor_on   = r_motor_on;
   assign coin_pulse = r_coin_pulse;
   assign done       = r_done;
   assign coins_paid = r_coins;

endmodule

// File: tb/tb_vend_payout_ctrl.sv
// Directed bench for vend_payout_ctrl: per-cycle vector table plus reset and timeout sequences.
// Outputs are compared as {busy, motor_on, coin_pulse, done, fault, coins_paid}.
module tb_vend_payout_ctrl;

   logic       clk;
   logic       rst;
   logic       req;
   logic       vend;
   logic [1:0] change;
   logic       motor_done;
   logic       coin_sense;
   logic       busy;
   logic       motor_on;
   logic       coin_pulse;
   logic       done;
   logic       fault;
   logic [1:0] coins_paid;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       req;
      logic       vend;
      logic [1:0] change;
      logic       md;
      logic       cs;
      logic [6:0] exp;
   } vec_t;

   vec_t tbl[$];

   vend_payout_ctrl #(
      .TIMEOUT (20),
      .PULSE_W (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .vend       (vend),
      .change     (change),
      .motor_done (motor_done),
      .coin_sense (coin_sense),
      .busy       (busy),
      .motor_on   (motor_on),
      .coin_pulse (coin_pulse),
      .done       (done),
      .fault      (fault),
      .coins_paid (coins_paid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] outs();
      return {busy, motor_on, coin_pulse, done, fault, coins_paid};
   endfunction

   function automatic void add(input logic r, input logic v, input logic [1:0] c,
                               input logic m, input logic s, input logic [6:0] e);
      vec_t t;
      t.req = r; t.vend = v; t.change = c; t.md = m; t.cs = s; t.exp = e;
      tbl.push_back(t);
   endfunction

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got {busy,motor,pulse,done,fault,coins}=%b expected %b", name, act, exp);
      end
   endtask

   // Drive inputs, let one rising edge sample them, return 1 time unit after that edge.
   task automatic step(input logic r, input logic v, input logic [1:0] c,
                       input logic m, input logic s);
      req = r; vend = v; change = c; motor_done = m; coin_sense = s;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      req = 1'b0; vend = 1'b0; change = 2'd0; motor_done = 1'b0; coin_sense = 1'b0;

      // vend=1, change=2: motor, two coin bursts, busy req and stray sense ignored
      add(1, 1, 2'd2, 0, 0, 7'b1100000);
      add(0, 0, 2'd0, 1, 0, 7'b1010000);
      add(1, 0, 2'd1, 0, 1, 7'b1010000);
      add(0, 0, 2'd0, 0, 0, 7'b1000000);
      add(0, 0, 2'd0, 0, 1, 7'b1010001);
      add(1, 1, 2'd3, 0, 0, 7'b1010001);
      add(0, 0, 2'd0, 0, 0, 7'b1000001);
      add(0, 0, 2'd0, 0, 1, 7'b1000010);
      add(0, 0, 2'd0, 0, 0, 7'b1001010);
      add(0, 0, 2'd0, 0, 0, 7'b0000010);
      // vend=0, change=0: done two cycles after req, reqs during done ignored, stray sense in idle
      add(1, 0, 2'd0, 0, 0, 7'b1000000);
      add(1, 1, 2'd3, 0, 0, 7'b1001000);
      add(1, 1, 2'd3, 0, 0, 7'b0000000);
      add(0, 0, 2'd0, 0, 1, 7'b0000000);
      add(0, 0, 2'd0, 0, 0, 7'b0000000);
      // vend=1, change=0: motor_done five cycles after req
      add(1, 1, 2'd0, 0, 0, 7'b1100000);
      add(0, 0, 2'd0, 0, 0, 7'b1100000);
      add(0, 0, 2'd0, 0, 0, 7'b1100000);
      add(0, 0, 2'd0, 0, 0, 7'b1100000);
      add(0, 0, 2'd0, 0, 0, 7'b1100000);
      add(0, 0, 2'd0, 1, 0, 7'b1000000);
      add(0, 0, 2'd0, 1, 0, 7'b1001000);
      add(0, 0, 2'd0, 0, 0, 7'b0000000);

      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", outs(), 7'b0000000);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].req, tbl[i].vend, tbl[i].change, tbl[i].md, tbl[i].cs);
         chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
      end

      // Asynchronous reset while waiting for the second coin
      step(1, 0, 2'd2, 0, 0);
      step(0, 0, 2'd0, 0, 0);
      step(0, 0, 2'd0, 0, 0);
      step(0, 0, 2'd0, 0, 1);
      chk("rstseq_coin1", outs(), 7'b1010001);
      step(0, 0, 2'd0, 0, 0);
      step(0, 0, 2'd0, 0, 0);
      chk("rstseq_wait2", outs(), 7'b1000001);
      step(0, 0, 2'd0, 0, 0);
      #2 rst = 1'b1;
      #1 chk("rstseq_async_clear", outs(), 7'b0000000);
      @(posedge clk);
      #3 rst = 1'b0;
      step(1, 0, 2'd1, 0, 0);
      chk("rstseq_first_req", outs(), 7'b1010000);
      step(0, 0, 2'd0, 0, 0);
      step(0, 0, 2'd0, 0, 0);
      step(0, 0, 2'd0, 0, 1);
      chk("rstseq_coin", outs(), 7'b1000001);
      step(0, 0, 2'd0, 0, 0);
      chk("rstseq_done", outs(), 7'b1001001);
      step(0, 0, 2'd0, 0, 0);
      chk("rstseq_idle", outs(), 7'b0000001);

      // change=1 with no coin_sense: COIN_WAIT entered on the third edge after req
      step(1, 0, 2'd1, 0, 0);
      chk("tmo_drive", outs(), 7'b1010000);
      step(0, 0, 2'd0, 0, 0);
      step(0, 0, 2'd0, 0, 0);
      chk("tmo_wait_entry", outs(), 7'b1000000);
      repeat (19) step(0, 0, 2'd0, 0, 0);
      chk("tmo_19", outs(), 7'b1000000);
      step(0, 0, 2'd0, 0, 0);
`ifdef PAYOUT_TIMEOUT_EN
      chk("tmo_20_fault", outs(), 7'b1000100);
      step(1, 1, 2'd3, 0, 0);
      chk("fault_req_ignored", outs(), 7'b1000100);
      step(0, 0, 2'd0, 0, 1);
      chk("fault_sense_ignored", outs(), 7'b1000100);
      step(0, 0, 2'd0, 0, 0);
      chk("fault_hold1", outs(), 7'b1000100);
      step(0, 0, 2'd0, 0, 0);
      chk("fault_hold2", outs(), 7'b1000100);
`else
      chk("tmo_20_still_wait", outs(), 7'b1000000);
      step(1, 1, 2'd3, 0, 0);
      chk("wait_req_ignored", outs(), 7'b1000000);
      step(0, 0, 2'd0, 0, 1);
      chk("late_coin", outs(), 7'b1000001);
      step(0, 0, 2'd0, 0, 0);
      chk("late_done", outs(), 7'b1001001);
      step(0, 0, 2'd0, 0, 0);
      chk("late_idle", outs(), 7'b0000001);
`endif
      #2 rst = 1'b1;
      #1 chk("final_reset", outs(), 7'b0000000);
      @(posedge clk);
      #3 rst = 1'b0;
      step(1, 0, 2'd0, 0, 0);
      chk("post_reset_req", outs(), 7'b1000000);
      step(0, 0, 2'd0, 0, 0);
      chk("post_reset_done", outs(), 7'b1001000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
